// File: rtl/nexys4ddr_ddr2_memtest_pkg.sv
// nexys4ddr_ddr2_memtest_pkg: shared register map, modes, CTI codes, FSM states and LFSR step
package nexys4ddr_ddr2_memtest_pkg;
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_BASE      = 3'd1;
  localparam logic [2:0] REG_LEN       = 3'd2;
  localparam logic [2:0] REG_SEED      = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;
  localparam logic [2:0] REG_ERR_ADDR  = 3'd5;
  localparam logic [2:0] REG_ERR_DATA  = 3'd6;
  localparam logic [2:0] REG_ERR_COUNT = 3'd7;
  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_NADDR = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WGAP, S_READ, S_RGAP, S_FINISH} state_t;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/nexys4ddr_ddr2_memtest_pattern.sv
// nexys4ddr_ddr2_memtest_pattern: LFSR state and mode mux producing the expected data word
module nexys4ddr_ddr2_memtest_pattern
  import nexys4ddr_ddr2_memtest_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [1:0]  mode,
  input  logic [31:0] seed,
  input  logic [31:0] adr,
  output logic [31:0] data
);
  logic [31:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= '0;
    else if (load) lfsr <= seed == '0 ? 32'd1 : seed;
    else if (advance) lfsr <= lfsr_step(lfsr);
  always_comb data = mode == MODE_ADDR ? adr : mode == MODE_NADDR ? ~adr : mode == MODE_LFSR ? lfsr : seed;
endmodule

// File: rtl/nexys4ddr_ddr2_memtest.sv
// nexys4ddr_ddr2_memtest: Wishbone burst write/read-compare memory tester with control slave
module nexys4ddr_ddr2_memtest
  import nexys4ddr_ddr2_memtest_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [2:0]  wbc_adr_i,
  input  logic [31:0] wbc_dat_i,
  input  logic        wbc_we_i,
  input  logic        wbc_cyc_i,
  input  logic        wbc_stb_i,
  output logic [31:0] wbc_dat_o,
  output logic        wbc_ack_o,
  output logic        busy_o
);
  state_t state, state_nx;
  logic [31:0] adr, remaining, base, len, seed, err_addr, err_data, err_count, tcnt, expected, rdata, src;
  logic [4:0] beat, burst_n, next_burst;
  logic [1:0] mode;
  logic read_only, start_req, abort_req, done, fail, tmo;
  logic in_burst, ack_beat, tmo_hit, mismatch, rewind, load, enters_burst, ctl_acc, ctl_wr, unused_rty;
  assign unused_rty = wbm_rty_i;
  assign in_burst = state == S_WRITE || state == S_READ;
  assign ack_beat = in_burst && wbm_ack_i && !wbm_err_i;
  assign tmo_hit = in_burst && !wbm_ack_i && !wbm_err_i && tcnt == 32'(TIMEOUT);
  assign mismatch = state == S_READ && ack_beat && wbm_dat_i != expected;
  assign rewind = state == S_WGAP && remaining == '0 && !abort_req;
  assign load = (state == S_IDLE && start_req) || rewind;
  assign src = (state == S_IDLE || rewind) ? len : remaining;
  assign next_burst = src < 32'(BURST_LEN) ? src[4:0] : 5'(BURST_LEN);
  assign enters_burst = !in_burst && (state_nx == S_WRITE || state_nx == S_READ);
  assign ctl_acc = wbc_cyc_i && wbc_stb_i && !wbc_ack_o;
  assign ctl_wr = ctl_acc && wbc_we_i;
  assign busy_o = state != S_IDLE;
  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_we_o = state == S_WRITE;
  assign wbm_sel_o = {4{in_burst}};
  assign wbm_adr_o = adr;
  assign wbm_dat_o = state == S_WRITE ? expected : 32'h0;
  assign wbm_cti_o = !in_burst ? CTI_CLASSIC : burst_n == 5'd1 ? CTI_CLASSIC : beat == 5'd1 ? CTI_EOB : CTI_INCR;
  assign wbm_bte_o = 2'b00;
  nexys4ddr_ddr2_memtest_pattern u_pattern (
    .clk(wb_clk_i), .rst(wb_rst_i), .load(load), .advance(ack_beat),
    .mode(mode), .seed(seed), .adr(adr), .data(expected)
  );
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:          if (start_req) state_nx = len == '0 ? S_FINISH : read_only ? S_READ : S_WRITE;
      S_WRITE, S_READ: if (wbm_err_i || tmo_hit) state_nx = S_IDLE;
                       else if (ack_beat && beat == 5'd1) state_nx = state == S_WRITE ? S_WGAP : S_RGAP;
      S_WGAP:          state_nx = abort_req ? S_FINISH : remaining != '0 ? S_WRITE : S_READ;
      S_RGAP:          state_nx = (abort_req || remaining == '0) ? S_FINISH : S_READ;
      default:         state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= S_IDLE;
      adr <= '0;
      remaining <= '0;
      beat <= '0;
      burst_n <= '0;
      tcnt <= '0;
    end else begin
      state <= state_nx;
      tcnt <= (in_burst && !wbm_ack_i) ? tcnt + 32'd1 : 32'd0;
      if (load) begin
        adr <= base;
        remaining <= len;
      end else if (ack_beat) begin
        adr <= adr + 32'd4;
        remaining <= remaining - 32'd1;
      end
      if (enters_burst) begin
        beat <= next_burst;
        burst_n <= next_burst;
      end else if (ack_beat) beat <= beat - 5'd1;
    end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      done <= 1'b0;
      fail <= 1'b0;
      tmo <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
      err_count <= '0;
    end else if (state == S_IDLE && start_req) begin
      done <= 1'b0;
      fail <= 1'b0;
      tmo <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
      err_count <= '0;
    end else begin
      if (state == S_FINISH || (in_burst && wbm_err_i) || tmo_hit) done <= 1'b1;
      if ((in_burst && wbm_err_i) || tmo_hit || mismatch) fail <= 1'b1;
      if (tmo_hit) tmo <= 1'b1;
      if (mismatch) err_count <= err_count + 32'(err_count != '1);
      if (mismatch && err_count == '0) begin
        err_addr <= adr;
        err_data <= wbm_dat_i;
      end
    end
  always_comb begin
    rdata = '0;
    case (wbc_adr_i)
      REG_CTRL:      rdata = {27'd0, read_only, mode, abort_req, 1'b0};
      REG_BASE:      rdata = base;
      REG_LEN:       rdata = len;
      REG_SEED:      rdata = seed;
      REG_STATUS:    rdata = {28'd0, tmo, fail, done, busy_o};
      REG_ERR_ADDR:  rdata = err_addr;
      REG_ERR_DATA:  rdata = err_data;
      REG_ERR_COUNT: rdata = err_count;
      default:       rdata = '0;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      wbc_ack_o <= 1'b0;
      wbc_dat_o <= '0;
      start_req <= 1'b0;
      abort_req <= 1'b0;
      mode <= '0;
      read_only <= 1'b0;
      base <= '0;
      len <= '0;
      seed <= '0;
    end else begin
      wbc_ack_o <= ctl_acc;
      start_req <= ctl_wr && wbc_adr_i == REG_CTRL && wbc_dat_i[0] && state == S_IDLE;
      abort_req <= (ctl_wr && wbc_adr_i == REG_CTRL && wbc_dat_i[1] && busy_o) || (abort_req && state != S_IDLE && state != S_FINISH);
      if (ctl_acc) wbc_dat_o <= rdata;
      if (ctl_wr && wbc_adr_i == REG_CTRL && state == S_IDLE) {read_only, mode} <= wbc_dat_i[4:2];
      if (ctl_wr && wbc_adr_i == REG_BASE) base <= {wbc_dat_i[31:2], 2'b00};
      if (ctl_wr && wbc_adr_i == REG_LEN) len <= wbc_dat_i;
      if (ctl_wr && wbc_adr_i == REG_SEED) seed <= wbc_dat_i;
    end
endmodule

// File: tb/tb_nexys4ddr_ddr2_memtest.sv
// tb_nexys4ddr_ddr2_memtest: randomized directed bench with a loop-based reference model of the test sequence
module tb_nexys4ddr_ddr2_memtest;
  localparam int BL = 4;
  localparam int TMO = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, wbc_dat_i, wbc_dat_o;
  logic [3:0] wbm_sel_o;
  logic [2:0] wbm_cti_o, wbc_adr_i;
  logic [1:0] wbm_bte_o;
  logic wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic wbc_we_i = 1'b0, wbc_cyc_i = 1'b0, wbc_stb_i = 1'b0, wbc_ack_o, busy_o;
  logic ack_en = 1'b1, err_en = 1'b0;
  logic [31:0] bad_adr = 32'hFFFF_FFFF;
  logic [31:0] mem [0:4095];
  logic [31:0] e_status, e_cnt, e_addr, e_data;
  int n_tests = 0, n_fail = 0, cyc_n = 0;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat; logic [2:0] cti; logic [3:0] sel; logic [1:0] bte; int cyc;} beat_t;
  beat_t log_q[$];
  beat_t exp_q[$];

  always #5 clk = ~clk;

  nexys4ddr_ddr2_memtest #(.BURST_LEN(BL), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbc_adr_i(wbc_adr_i), .wbc_dat_i(wbc_dat_i), .wbc_we_i(wbc_we_i), .wbc_cyc_i(wbc_cyc_i),
    .wbc_stb_i(wbc_stb_i), .wbc_dat_o(wbc_dat_o), .wbc_ack_o(wbc_ack_o), .busy_o(busy_o)
  );

  assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ack_en & ~err_en;
  assign wbm_err_i = wbm_cyc_o & wbm_stb_o & err_en;
  assign wbm_rty_i = 1'b0;
  assign wbm_dat_i = mem[wbm_adr_o[13:2]] ^ (wbm_adr_o == bad_adr ? 32'h8 : 32'h0);

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      log_q.push_back('{wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_cti_o, wbm_sel_o, wbm_bte_o, cyc_n});
      if (wbm_we_o) mem[wbm_adr_o[13:2]] <= wbm_dat_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wbc_xfer(input logic we, input logic [2:0] a, input logic [31:0] d, output logic [31:0] q);
    int n;
    n = 0;
    @(negedge clk);
    wbc_cyc_i = 1'b1; wbc_stb_i = 1'b1; wbc_we_i = we; wbc_adr_i = a; wbc_dat_i = d;
    do begin @(posedge clk); #1; n++; end while (!wbc_ack_o && n < 8);
    check("wbc_ack_latency", 32'(n), 32'd1);
    q = wbc_dat_o;
    @(negedge clk);
    wbc_cyc_i = 1'b0; wbc_stb_i = 1'b0; wbc_we_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    wbc_xfer(1'b1, a, d, q);
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wbc_xfer(1'b0, a, 32'h0, q);
    check(tag, q, exp);
  endtask

  task automatic prep(input logic [31:0] b, input int n, input logic [1:0] m, input logic [31:0] s, input logic ro, input logic [31:0] bad);
    logic [31:0] l, a;
    int st, sz;
    beat_t e;
    exp_q.delete();
    for (int p = (ro ? 1 : 0); p < 2; p++) begin
      l = (s == 32'h0) ? 32'h1 : s;
      for (int i = 0; i < n; i++) begin
        a = {b[31:2], 2'b00} + 32'(4 * i);
        st = i - (i % BL);
        sz = (n - st < BL) ? n - st : BL;
        e.we = (p == 0);
        e.adr = a;
        e.dat = m == 2'd0 ? a : m == 2'd1 ? ~a : m == 2'd2 ? l : s;
        e.cti = sz == 1 ? 3'b000 : (i == st + sz - 1) ? 3'b111 : 3'b010;
        e.sel = 4'hF;
        e.bte = 2'b00;
        e.cyc = (i == st && exp_q.size() != 0) ? 2 : 1;
        exp_q.push_back(e);
        l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
      end
    end
    bad_adr = bad;
    e_status = 32'h2; e_cnt = 0; e_addr = 0; e_data = 0;
    foreach (exp_q[i])
      if (!exp_q[i].we && exp_q[i].adr == bad) begin
        e_status = 32'h6; e_cnt = 1; e_addr = bad; e_data = exp_q[i].dat ^ 32'h8;
      end
  endtask

  task automatic go(input logic [31:0] b, input int n, input logic [1:0] m, input logic [31:0] s, input logic ro);
    wr(3'd1, b);
    wr(3'd2, 32'(n));
    wr(3'd3, s);
    log_q.delete();
    wr(3'd0, {27'd0, ro, m, 2'b01});
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (busy_o && k < 5000);
    check({tag, " idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic finish_run(input string tag);
    wait_idle(tag);
    check({tag, " beats"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s we[%0d]", tag, i), 32'(log_q[i].we), 32'(exp_q[i].we));
      check($sformatf("%s adr[%0d]", tag, i), log_q[i].adr, exp_q[i].adr);
      if (exp_q[i].we) check($sformatf("%s dat[%0d]", tag, i), log_q[i].dat, exp_q[i].dat);
      check($sformatf("%s cti[%0d]", tag, i), 32'(log_q[i].cti), 32'(exp_q[i].cti));
      check($sformatf("%s selbte[%0d]", tag, i), {26'd0, log_q[i].sel, log_q[i].bte}, {26'd0, exp_q[i].sel, exp_q[i].bte});
      if (i > 0) check($sformatf("%s gap[%0d]", tag, i), 32'(log_q[i].cyc - log_q[i-1].cyc), 32'(exp_q[i].cyc));
    end
    rd_check({tag, " status"}, 3'd4, e_status);
    rd_check({tag, " err_count"}, 3'd7, e_cnt);
    rd_check({tag, " err_addr"}, 3'd5, e_addr);
    rd_check({tag, " err_data"}, 3'd6, e_data);
    bad_adr = 32'hFFFF_FFFF;
  endtask

  task automatic run(input string tag, input logic [31:0] b, input int n, input logic [1:0] m, input logic [31:0] s, input logic ro, input logic [31:0] bad);
    prep(b, n, m, s, ro, bad);
    go(b, n, m, s, ro);
    finish_run(tag);
  endtask

  initial begin
    int cnt;
    logic [31:0] b, s, bad;
    int n;
    logic [1:0] m;
    repeat (3) @(posedge clk);
    #1;
    check("reset wbm_cyc_stb_we", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    check("reset wbm_sel_cti_bte", {23'd0, wbm_sel_o, wbm_cti_o, wbm_bte_o}, 32'd0);
    check("reset wbm_adr", wbm_adr_o, 32'd0);
    check("reset wbm_dat", wbm_dat_o, 32'd0);
    check("reset wbc_dat", wbc_dat_o, 32'd0);
    check("reset ack_busy", {30'd0, wbc_ack_o, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_check("reset status", 3'd4, 32'd0);
    rd_check("reset len", 3'd2, 32'd0);

    prep(32'h100, 8, 2'd0, 32'h0, 1'b0, 32'hFFFF_FFFF);
    go(32'h100, 8, 2'd0, 32'h0, 1'b0);
    check("start ack cycle cyc", 32'(wbm_cyc_o), 32'd0);
    @(posedge clk); #1;
    check("start+1 cyc", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
    check("start+1 adr", wbm_adr_o, 32'h100);
    check("start+1 dat", wbm_dat_o, 32'h100);
    finish_run("pass8");

    wr(3'd1, 32'h103);
    rd_check("base masked", 3'd1, 32'h100);

    run("len5", 32'h100, 5, 2'd0, 32'h0, 1'b0, 32'hFFFF_FFFF);
    run("corrupt", 32'h100, 8, 2'd0, 32'h0, 1'b0, 32'h108);

    ack_en = 1'b0;
    go(32'h100, 8, 2'd0, 32'h0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (wbm_cyc_o) cnt++;
      else if (cnt > 0) break;
    end
    check("timeout cyc cycles", 32'(cnt), 32'd16);
    check("timeout busy", 32'(busy_o), 32'd0);
    rd_check("timeout status", 3'd4, 32'hE);
    ack_en = 1'b1;

    err_en = 1'b1;
    go(32'h100, 8, 2'd0, 32'h0, 1'b0);
    wait_idle("err");
    check("err beats", 32'(log_q.size()), 32'd0);
    rd_check("err status", 3'd4, 32'h6);
    err_en = 1'b0;

    go(32'h100, 0, 2'd0, 32'h0, 1'b0);
    cnt = 0;
    @(posedge clk); #1;
    cnt += 32'(wbm_cyc_o);
    @(posedge clk); #1;
    check("len0 busy at t+2", 32'(busy_o), 32'd0);
    repeat (4) begin @(posedge clk); #1; cnt += 32'(wbm_cyc_o); end
    check("len0 no cyc", 32'(cnt), 32'd0);
    rd_check("len0 status", 3'd4, 32'h2);

    prep(32'h200, 32, 2'd2, 32'h0, 1'b0, 32'hFFFF_FFFF);
    go(32'h200, 32, 2'd2, 32'h0, 1'b0);
    wr(3'd0, 32'h1);
    check("restart busy", 32'(busy_o), 32'd1);
    finish_run("lfsr seed0");

    run("const write", 32'h400, 10, 2'd3, 32'hA5A5_5A5A, 1'b0, 32'hFFFF_FFFF);
    run("const readonly", 32'h400, 10, 2'd3, 32'hA5A5_5A5A, 1'b1, 32'h40C);

    go(32'h800, 64, 2'd1, 32'h0, 1'b0);
    repeat (6) @(posedge clk);
    wr(3'd0, 32'h2);
    wait_idle("abort");
    check("abort boundary", 32'(log_q.size() % BL), 32'd0);
    check("abort early", 32'(log_q.size() < 128), 32'd1);
    rd_check("abort status", 3'd4, 32'h2);

    for (int r = 0; r < 6; r++) begin
      b = 32'($urandom_range(0, 32'h2000));
      n = $urandom_range(1, 40);
      m = 2'($urandom_range(0, 3));
      s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      bad = ($urandom_range(0, 1) == 1) ? {b[31:2], 2'b00} + 32'(4 * $urandom_range(0, n - 1)) : 32'hFFFF_FFFF;
      run($sformatf("rand%0d", r), b, n, m, s, 1'b0, bad);
    end

    go(32'h100, 64, 2'd0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midburst reset cyc", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midburst reset busy", 32'(busy_o), 32'd0);
    rd_check("midburst reset status", 3'd4, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
